// File: rtl/rtc_bus_responder.sv
// RTC chip model on the multiplexed address/data strobe bus: BCD time/date,
// a BCD countdown timer with a level interrupt, all stepped by a 1 Hz tick.
module rtc_bus_responder #(
   parameter logic [7:0] RESET_DAY   = 8'h01,
   parameter logic [7:0] RESET_MONTH = 8'h01,
   parameter logic [7:0] RESET_YEAR  = 8'h00
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       cs_n,
   input  logic       ad_n,
   input  logic       rd_n,
   input  logic       wr_n,
   input  logic [7:0] ad_in,
   output logic [7:0] ad_out,
   output logic       ad_oe,
   input  logic       tick,
   output logic       irq_n
);

   typedef enum logic [1:0] {IDLE, ADDR, WDATA, RDATA} state_t;

   state_t     state_reg;
   logic [7:0] addr_reg, wdata_reg;
   logic [7:0] sec_reg, min_reg, hour_reg, day_reg, month_reg, year_reg;
   logic [7:0] tsec_reg, tmin_reg, thour_reg;

   logic [7:0] sec_next, min_next, hour_next, day_next;
   logic [7:0] tsec_next, tmin_next, thour_next;
   logic       timer_expire;
   logic       proto_err, wr_commit;
   logic [7:0] rd_data;

   function automatic logic [7:0] bcd_inc(input logic [7:0] v);
      return (v[3:0] == 4'h9) ? {v[7:4] + 4'h1, 4'h0} : v + 8'h01;
   endfunction

   function automatic logic [7:0] bcd_dec(input logic [7:0] v);
      return (v[3:0] == 4'h0) ? {v[7:4] - 4'h1, 4'h9} : v - 8'h01;
   endfunction

   // Tick results are computed from the pre-write values; a committing
   // write then overrides only its own register.
   always_comb begin
      sec_next     = sec_reg;
      min_next     = min_reg;
      hour_next    = hour_reg;
      day_next     = day_reg;
      tsec_next    = tsec_reg;
      tmin_next    = tmin_reg;
      thour_next   = thour_reg;
      timer_expire = 1'b0;
      if (tick) begin
         if (sec_reg >= 8'h59) begin
            sec_next = 8'h00;
            if (min_reg >= 8'h59) begin
               min_next = 8'h00;
               if (hour_reg >= 8'h23) begin
                  hour_next = 8'h00;
                  day_next  = (day_reg >= 8'h31) ? 8'h01 : bcd_inc(day_reg);
               end else begin
                  hour_next = bcd_inc(hour_reg);
               end
            end else begin
               min_next = bcd_inc(min_reg);
            end
         end else begin
            sec_next = bcd_inc(sec_reg);
         end

         if ({thour_reg, tmin_reg, tsec_reg} != 24'h0) begin
            if (tsec_reg != 8'h00) begin
               tsec_next = bcd_dec(tsec_reg);
            end else begin
               tsec_next = 8'h59;
               if (tmin_reg != 8'h00) begin
                  tmin_next = bcd_dec(tmin_reg);
               end else begin
                  tmin_next  = 8'h59;
                  thour_next = bcd_dec(thour_reg);
               end
            end
            timer_expire = ({thour_next, tmin_next, tsec_next} == 24'h0);
         end
      end
   end

   assign proto_err = ~rd_n & ~wr_n;
   assign wr_commit = (state_reg == WDATA) && !proto_err && (cs_n || wr_n);

   always_comb begin
      case (addr_reg)
         8'h21:   rd_data = sec_reg;
         8'h22:   rd_data = min_reg;
         8'h23:   rd_data = hour_reg;
         8'h24:   rd_data = day_reg;
         8'h25:   rd_data = month_reg;
         8'h26:   rd_data = year_reg;
         8'h41:   rd_data = tsec_reg;
         8'h42:   rd_data = tmin_reg;
         8'h43:   rd_data = thour_reg;
         default: rd_data = 8'h00;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg <= IDLE;
         addr_reg  <= 8'h00;
         wdata_reg <= 8'h00;
         ad_out    <= 8'h00;
         ad_oe     <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (!cs_n && !proto_err) begin
                  if (!ad_n && !wr_n) begin
                     state_reg <= ADDR;
                     addr_reg  <= ad_in;
                  end else if (ad_n && !wr_n) begin
                     state_reg <= WDATA;
                     wdata_reg <= ad_in;
                  end else if (ad_n && !rd_n) begin
                     state_reg <= RDATA;
                  end
               end
            end
            ADDR: begin
               if (cs_n || wr_n) state_reg <= IDLE;
               else              addr_reg  <= ad_in;
            end
            WDATA: begin
               if (proto_err || cs_n || wr_n) state_reg <= IDLE;
               else                           wdata_reg <= ad_in;
            end
            RDATA: begin
               if (proto_err || cs_n || rd_n) begin
                  ad_oe     <= 1'b0;
                  state_reg <= IDLE;
               end else begin
                  ad_out <= rd_data;
                  ad_oe  <= 1'b1;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sec_reg   <= 8'h00;
         min_reg   <= 8'h00;
         hour_reg  <= 8'h00;
         day_reg   <= RESET_DAY;
         month_reg <= RESET_MONTH;
         year_reg  <= RESET_YEAR;
         tsec_reg  <= 8'h00;
         tmin_reg  <= 8'h00;
         thour_reg <= 8'h00;
         irq_n     <= 1'b1;
      end else begin
         sec_reg   <= sec_next;
         min_reg   <= min_next;
         hour_reg  <= hour_next;
         day_reg   <= day_next;
         tsec_reg  <= tsec_next;
         tmin_reg  <= tmin_next;
         thour_reg <= thour_next;
         if (timer_expire) irq_n <= 1'b0;
         if (wr_commit) begin
            case (addr_reg)
               8'h21:   sec_reg   <= wdata_reg;
               8'h22:   min_reg   <= wdata_reg;
               8'h23:   hour_reg  <= wdata_reg;
               8'h24:   day_reg   <= wdata_reg;
               8'h25:   month_reg <= wdata_reg;
               8'h26:   year_reg  <= wdata_reg;
               8'h41:   tsec_reg  <= wdata_reg;
               8'h42:   tmin_reg  <= wdata_reg;
               8'h43:   thour_reg <= wdata_reg;
               default: ;
            endcase
            // Any timer write acknowledges the interrupt, even on an expiry edge.
            if (addr_reg >= 8'h41 && addr_reg <= 8'h43) irq_n <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_rtc_bus_responder.sv
// Directed and random bus traffic against a decimal time/timer reference model.
module tb_rtc_bus_responder;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       cs_n = 1'b1, ad_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1, tick = 1'b0;
   logic [7:0] ad_in = 8'h00;
   logic [7:0] ad_out;
   logic       ad_oe, irq_n;

   rtc_bus_responder #(
      .RESET_DAY(8'h01), .RESET_MONTH(8'h01), .RESET_YEAR(8'h00)
   ) dut (
      .clk(clk), .reset(reset), .cs_n(cs_n), .ad_n(ad_n), .rd_n(rd_n),
      .wr_n(wr_n), .ad_in(ad_in), .ad_out(ad_out), .ad_oe(ad_oe),
      .tick(tick), .irq_n(irq_n)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model kept as plain decimal numbers.
   int m_sec, m_min, m_hour, m_day, m_month, m_year, m_ts, m_tm, m_th;
   logic m_irq_n;

   logic [7:0] map_addr [9] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h41, 8'h42, 8'h43};
   int         lo_v     [9] = '{0, 0, 0, 1, 1, 0, 0, 0, 0};
   int         hi_v     [9] = '{59, 59, 23, 31, 12, 99, 5, 1, 1};

   function automatic int bcd2int(input logic [7:0] b);
      return int'(b[7:4]) * 10 + int'(b[3:0]);
   endfunction

   function automatic logic [7:0] int2bcd(input int v);
      return 8'((v / 10) * 16 + (v % 10));
   endfunction

   function automatic bit is_mapped(input logic [7:0] a);
      for (int i = 0; i < 9; i++) if (map_addr[i] == a) return 1'b1;
      return 1'b0;
   endfunction

   task automatic model_reset();
      m_sec = 0; m_min = 0; m_hour = 0;
      m_day = 1; m_month = 1; m_year = 0;
      m_ts = 0; m_tm = 0; m_th = 0;
      m_irq_n = 1'b1;
   endtask

   task automatic model_tick();
      int tod, t;
      tod = m_hour * 3600 + m_min * 60 + m_sec + 1;
      if (tod >= 86400) begin
         tod = 0;
         m_day = (m_day >= 31) ? 1 : m_day + 1;
      end
      m_hour = tod / 3600; m_min = (tod % 3600) / 60; m_sec = tod % 60;
      t = m_th * 3600 + m_tm * 60 + m_ts;
      if (t > 0) begin
         t = t - 1;
         if (t == 0) m_irq_n = 1'b0;
         m_th = t / 3600; m_tm = (t % 3600) / 60; m_ts = t % 60;
      end
   endtask

   task automatic model_write(input logic [7:0] a, input logic [7:0] d);
      case (a)
         8'h21: m_sec   = bcd2int(d);
         8'h22: m_min   = bcd2int(d);
         8'h23: m_hour  = bcd2int(d);
         8'h24: m_day   = bcd2int(d);
         8'h25: m_month = bcd2int(d);
         8'h26: m_year  = bcd2int(d);
         8'h41: begin m_ts = bcd2int(d); m_irq_n = 1'b1; end
         8'h42: begin m_tm = bcd2int(d); m_irq_n = 1'b1; end
         8'h43: begin m_th = bcd2int(d); m_irq_n = 1'b1; end
         default: ;
      endcase
   endtask

   function automatic logic [7:0] model_read(input logic [7:0] a);
      case (a)
         8'h21:   return int2bcd(m_sec);
         8'h22:   return int2bcd(m_min);
         8'h23:   return int2bcd(m_hour);
         8'h24:   return int2bcd(m_day);
         8'h25:   return int2bcd(m_month);
         8'h26:   return int2bcd(m_year);
         8'h41:   return int2bcd(m_ts);
         8'h42:   return int2bcd(m_tm);
         8'h43:   return int2bcd(m_th);
         default: return 8'h00;
      endcase
   endfunction

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%02h expected=%02h", tag, obs, exp);
      end
   endtask

   task automatic addr_phase(input logic [7:0] a);
      cs_n = 1'b0; ad_n = 1'b0; wr_n = 1'b0; rd_n = 1'b1; ad_in = a;
      repeat (2) @(negedge clk);
      wr_n = 1'b1; cs_n = 1'b1; ad_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic bus_write(input logic [7:0] a, input logic [7:0] d, input bit with_tick);
      addr_phase(a);
      cs_n = 1'b0; ad_n = 1'b1; wr_n = 1'b0; ad_in = d;
      repeat (2) @(negedge clk);
      wr_n = 1'b1; cs_n = 1'b1; tick = with_tick;
      @(negedge clk);
      tick = 1'b0;
      if (with_tick) model_tick();
      model_write(a, d);
      $display("WR  addr=%02h data=%02h tick=%0d", a, d, with_tick);
      check("irq_n_after_write", {7'b0, irq_n}, {7'b0, m_irq_n});
   endtask

   task automatic bus_read(input logic [7:0] a);
      logic [7:0] exp;
      addr_phase(a);
      cs_n = 1'b0; ad_n = 1'b1; rd_n = 1'b0; wr_n = 1'b1;
      @(negedge clk);
      check("ad_oe_at_entry", {7'b0, ad_oe}, 8'h00);
      @(negedge clk);
      exp = model_read(a);
      check("ad_oe_read", {7'b0, ad_oe}, 8'h01);
      check("ad_out_read", ad_out, exp);
      rd_n = 1'b1; cs_n = 1'b1;
      @(negedge clk);
      check("ad_oe_release", {7'b0, ad_oe}, 8'h00);
      check("ad_out_held", ad_out, exp);
      $display("RD  addr=%02h data=%02h expect=%02h", a, ad_out, exp);
   endtask

   task automatic do_tick();
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      model_tick();
      $display("TICK irq_n=%0d expect=%0d", irq_n, m_irq_n);
      check("irq_n_after_tick", {7'b0, irq_n}, {7'b0, m_irq_n});
   endtask

   initial begin
      model_reset();
      repeat (3) @(negedge clk);
      check("reset_ad_out", ad_out, 8'h00);
      check("reset_ad_oe", {7'b0, ad_oe}, 8'h00);
      check("reset_irq_n", {7'b0, irq_n}, 8'h01);
      reset = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 9; i++) bus_read(map_addr[i]);

      // Basic write/read and unmapped read
      bus_write(8'h22, 8'h45, 1'b0);
      bus_read(8'h22);
      bus_read(8'h30);

      // Full rollover of the time-of-day into the day
      bus_write(8'h21, 8'h59, 1'b0);
      bus_write(8'h22, 8'h59, 1'b0);
      bus_write(8'h23, 8'h23, 1'b0);
      bus_write(8'h24, 8'h31, 1'b0);
      do_tick();
      for (int i = 0; i < 6; i++) bus_read(map_addr[i]);

      // Countdown expiry and acknowledge
      bus_write(8'h41, 8'h02, 1'b0);
      bus_write(8'h42, 8'h00, 1'b0);
      bus_write(8'h43, 8'h00, 1'b0);
      do_tick();
      do_tick();
      check("irq_after_expiry", {7'b0, irq_n}, 8'h00);
      do_tick();
      bus_read(8'h41);
      bus_write(8'h41, 8'h00, 1'b0);
      check("irq_after_ack", {7'b0, irq_n}, 8'h01);

      // Both strobes low during a write data phase: no commit
      addr_phase(8'h23);
      cs_n = 1'b0; ad_n = 1'b1; wr_n = 1'b0; ad_in = 8'h12;
      repeat (2) @(negedge clk);
      rd_n = 1'b0;
      @(negedge clk);
      check("proto_err_wr_oe", {7'b0, ad_oe}, 8'h00);
      @(negedge clk);
      cs_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
      @(negedge clk);
      $display("ERR write aborted addr=23");
      bus_read(8'h23);

      // Both strobes low during a read data phase: drop the bus
      addr_phase(8'h21);
      cs_n = 1'b0; ad_n = 1'b1; rd_n = 1'b0; wr_n = 1'b1;
      repeat (2) @(negedge clk);
      check("proto_err_rd_oe_before", {7'b0, ad_oe}, 8'h01);
      wr_n = 1'b0;
      @(negedge clk);
      check("proto_err_rd_oe", {7'b0, ad_oe}, 8'h00);
      @(negedge clk);
      cs_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
      @(negedge clk);
      check("proto_err_rd_idle_oe", {7'b0, ad_oe}, 8'h00);
      $display("ERR read aborted addr=21");
      bus_read(8'h22);

      // Tick coinciding with a committing write
      bus_write(8'h21, 8'h59, 1'b0);
      bus_write(8'h22, 8'h59, 1'b0);
      bus_write(8'h23, 8'h05, 1'b0);
      bus_write(8'h22, 8'h10, 1'b1);
      for (int i = 0; i < 4; i++) bus_read(map_addr[i]);
      bus_write(8'h21, 8'h30, 1'b1);
      bus_read(8'h21);
      bus_read(8'h22);

      // Asynchronous reset while the responder drives the bus
      addr_phase(8'h22);
      cs_n = 1'b0; ad_n = 1'b1; rd_n = 1'b0; wr_n = 1'b1;
      repeat (2) @(negedge clk);
      check("async_pre_oe", {7'b0, ad_oe}, 8'h01);
      #2 reset = 1'b0;
      #1;
      check("async_rst_oe", {7'b0, ad_oe}, 8'h00);
      check("async_rst_ad_out", ad_out, 8'h00);
      check("async_rst_irq", {7'b0, irq_n}, 8'h01);
      cs_n = 1'b1; rd_n = 1'b1;
      @(negedge clk);
      reset = 1'b1;
      model_reset();
      $display("RST during read");
      @(negedge clk);

      // Reset during a write data phase aborts the commit
      bus_write(8'h23, 8'h11, 1'b0);
      addr_phase(8'h23);
      cs_n = 1'b0; ad_n = 1'b1; wr_n = 1'b0; ad_in = 8'h44;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      cs_n = 1'b1; wr_n = 1'b1;
      @(negedge clk);
      reset = 1'b1;
      model_reset();
      $display("RST during write addr=23");
      @(negedge clk);
      bus_read(8'h23);

      // Random traffic
      for (int n = 0; n < 150; n++) begin
         int op, idx;
         logic [7:0] a;
         op = int'($urandom_range(0, 4));
         idx = int'($urandom_range(0, 8));
         case (op)
            0, 4: bus_write(map_addr[idx],
                            int2bcd(int'($urandom_range(lo_v[idx], hi_v[idx]))), op == 4);
            1: begin
               if ($urandom_range(0, 1) == 0) a = map_addr[idx];
               else a = 8'($urandom_range(0, 255));
               bus_read(a);
            end
            2: do_tick();
            default: begin
               do a = 8'($urandom_range(0, 255)); while (is_mapped(a));
               bus_write(a, 8'($urandom_range(0, 255)), 1'b0);
            end
         endcase
      end
      for (int i = 0; i < 9; i++) bus_read(map_addr[i]);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/rtc_bus_responder.md
Name: rtc_bus_responder

Overview:
- Synthesizable responder for the multiplexed address/data RTC bus driven by the host-side bus sequencer.
- Decodes active-low CS/AD/RD/WR strobes, latches the address, and services byte reads and writes to a BCD time/date and countdown-timer register file.
- Advances time on a 1 Hz tick input.
- Sits on the FPGA side as an RTC chip model for integration and bench use; it is the counterpart of the bus sequencer.

Parameters:
- RESET_DAY, 8'h01, BCD day loaded at reset
- RESET_MONTH, 8'h01, BCD month loaded at reset
- RESET_YEAR, 8'h00, BCD year loaded at reset

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- cs_n  input  1  chip select, active low
- ad_n  input  1  address strobe, active low (0 = address phase, 1 = data phase)
- rd_n  input  1  read strobe, active low
- wr_n  input  1  write strobe, active low
- ad_in  input  8  bus value from host
- ad_out  output  8  read data to host
- ad_oe  output  1  1 = responder drives bus
- tick  input  1  one-cycle 1 Hz pulse
- irq_n  output  1  timer-expired interrupt, active low, level

Behaviour:
- Strobes are synchronous to clk; no synchronizers are used.
- Reset (reset=0, async): state=IDLE, addr=0, ad_out=0, ad_oe=0, irq_n=1, sec/min/hour=00, day=RESET_DAY, month=RESET_MONTH, year=RESET_YEAR, timer regs=00.
- Register map:
  - 0x21 sec, 0x22 min, 0x23 hour, 0x24 day, 0x25 month, 0x26 year
  - 0x41 timer sec, 0x42 timer min, 0x43 timer hour
  - Any other address: reads 0x00, writes ignored.
- Bus FSM states: IDLE, ADDR, WDATA, RDATA.
  - IDLE -> ADDR when cs_n=0, ad_n=0, wr_n=0.
  - ADDR: addr <= ad_in on every cycle spent in ADDR, so the last value wins. Exit to IDLE when wr_n=1 or cs_n=1.
  - IDLE -> WDATA when cs_n=0, ad_n=1, wr_n=0, rd_n=1.
  - WDATA: wdata <= ad_in on every cycle. On exit (wr_n=1 or cs_n=1), commit wdata to reg[addr] on that exit edge, then go to IDLE.
  - IDLE -> RDATA when cs_n=0, ad_n=1, rd_n=0, wr_n=1.
  - RDATA: ad_out <= reg[addr] and ad_oe <= 1 from the cycle after entry (latency 1). On cs_n=1 or rd_n=1: ad_oe <= 0, ad_out held, go to IDLE.
  - rd_n=0 and wr_n=0 together is a protocol error: no transition from IDLE; from WDATA/RDATA go to IDLE with no commit and ad_oe=0.
  - reset mid-transaction aborts it with no commit.
- Timekeeping on tick=1, BCD:
  - sec increments.
  - sec at or above 0x59 wraps to 0x00 and carries to min.
  - min, same rule at 0x59, carries to hour.
  - hour wraps at or above 0x23 to 0x00 and carries to day.
  - day at or above 0x31 wraps to 0x01.
  - month and year never auto-increment.
  - BCD digit increment: low nibble 9 -> 0 with high nibble +1. Non-BCD written values are stored as written; the wrap compare handles them.
- Countdown timer on tick, when {thour,tmin,tsec} != 0:
  - BCD decrement with borrow; sec/min borrow reloads 0x59.
  - A transition to all-zero sets irq_n=0.
  - irq_n returns to 1 on any bus write to 0x41-0x43.
- Simultaneous tick and committing write:
  - Bus write wins for the addressed register.
  - Other registers still update from the tick, including any carry generated by the pre-write value.

Test Plan:
- Reset -> all outputs at reset values; read 0x24 returns 0x01 with ad_oe=1 one cycle after RDATA entry.
- Address phase 0x22, then data write 0x45, then read 0x22 -> ad_out=0x45; read 0x30 -> 0x00.
- Write sec=0x59, min=0x59, hour=0x23, day=0x31; pulse tick -> sec=00, min=00, hour=00, day=0x01, month unchanged.
- Write timer sec=0x02, min=hour=0x00; two ticks -> after second tick irq_n=0; write 0x41 -> irq_n=1.
- rd_n and wr_n both low during data phase -> no register change, ad_oe=0, FSM returns to IDLE.
- Assert reset during WDATA before wr_n rises -> target register keeps its reset value.
